// File: rtl/keypad_port_pkg.sv
// Shared definitions for the memory-mapped keypad port: debounce FSM states,
// register offsets from BASE_ADDR and STATUS bit positions.
package keypad_port_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } kpState_t;

  localparam logic [31:0] KEYDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS  = 32'd2;

  localparam int unsigned STATUS_VALID_BIT   = 0;
  localparam int unsigned STATUS_OVERRUN_BIT = 1;

endpackage

// File: rtl/keypad_scan.sv
// Column scanner for a 4x4 active-low keypad: drives one column low at a time,
// synchronizes the rows and reports one result per full scan frame.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       frameValid,
  output logic       frameHit,
  output logic [3:0] frameCode
);

  localparam int unsigned DIV_W = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] divCnt;
  logic [1:0]       colIdx;
  logic [3:0]       rowMeta;
  logic [3:0]       rowSync;
  logic             accHit;
  logic [3:0]       accCode;
  logic             lastCycle;
  logic             colHit;
  logic [1:0]       colRow;
  logic             curHit;
  logic             newHit;
  logic [3:0]       newCode;

  assign lastCycle = (divCnt == DIV_W'(SCAN_DIV - 1));

  // One-hot active-low column drive from the current column index.
  always_comb col = ~(4'b0001 << colIdx);

  // Lowest low row in the current column; merge with earlier columns of the frame.
  always_comb begin
    colHit = 1'b0;
    colRow = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!colHit && !rowSync[r]) begin
        colHit = 1'b1;
        colRow = 2'(r);
      end
    end
    curHit  = (colIdx == 2'd0) ? 1'b0 : accHit;
    newHit  = curHit | colHit;
    newCode = curHit ? accCode : {colRow, colIdx};
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rowMeta <= '0;
      rowSync <= '0;
    end else begin
      rowMeta <= row;
      rowSync <= rowMeta;
    end
  end

  // Column period divider and column index.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      divCnt <= '0;
      colIdx <= '0;
    end else if (lastCycle) begin
      divCnt <= '0;
      colIdx <= colIdx + 2'd1;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  // Frame accumulation; a one-cycle frameValid pulse follows the last column sample.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      accHit     <= 1'b0;
      accCode    <= '0;
      frameValid <= 1'b0;
      frameHit   <= 1'b0;
      frameCode  <= '0;
    end else begin
      frameValid <= 1'b0;
      if (lastCycle) begin
        accHit  <= newHit;
        accCode <= newCode;
        if (colIdx == 2'd3) begin
          frameValid <= 1'b1;
          frameHit   <= newHit;
          frameCode  <= newCode;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_port.sv
// Memory-mapped keypad port: debounces scan frames into key presses and
// exposes them through KEYDATA and STATUS registers on the CPU IO bus.
module keypad_port #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_FRAMES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFFFC10
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        isR,
  input  logic [3:0]  isW,
  input  logic [31:0] addr,
  input  logic [15:0] dW,
  output logic [15:0] dR,
  input  logic [3:0]  row,
  output logic [3:0]  col
);

  import keypad_port_pkg::*;

  localparam int unsigned DEB_W     = $clog2(DEB_FRAMES + 1);
  localparam logic [31:0] KEY_ADDR  = BASE_ADDR + KEYDATA_OFS;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + STATUS_OFS;

  kpState_t         state, stateNext;
  logic [3:0]       cand, candNext;
  logic [DEB_W-1:0] debCnt, debCntNext;
  logic             latch;
  logic             frameValid, frameHit;
  logic [3:0]       frameCode;
  logic [3:0]       keyCode;
  logic             valid, overrun;
  logic             rdKey, rdStat, clrOvr;
  logic [15:0]      statusWord;
  logic             unusedDw;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) uScan (
    .clk        (clk),
    .clrn       (clrn),
    .row        (row),
    .col        (col),
    .frameValid (frameValid),
    .frameHit   (frameHit),
    .frameCode  (frameCode)
  );

  assign rdKey    = isR && (addr == KEY_ADDR);
  assign rdStat   = isR && (addr == STAT_ADDR);
  assign clrOvr   = (|isW) && (addr == STAT_ADDR) && dW[STATUS_OVERRUN_BIT];
  assign unusedDw = ^{dW[15:2], dW[0]};

  // Debounce state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      cand   <= '0;
      debCnt <= '0;
    end else begin
      state  <= stateNext;
      cand   <= candNext;
      debCnt <= debCntNext;
    end
  end

  // Debounce next-state logic; the frame that opens a debounce window counts as its first frame.
  always_comb begin
    stateNext  = state;
    candNext   = cand;
    debCntNext = debCnt;
    latch      = 1'b0;
    if (frameValid) begin
      unique case (state)
        IDLE: begin
          if (frameHit) begin
            candNext = frameCode;
            if (DEB_FRAMES <= 1) begin
              latch     = 1'b1;
              stateNext = HELD;
            end else begin
              debCntNext = DEB_W'(1);
              stateNext  = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (frameHit && (frameCode == cand)) begin
            if (32'(debCnt) + 32'd1 >= DEB_FRAMES) begin
              latch     = 1'b1;
              stateNext = HELD;
            end else begin
              debCntNext = debCnt + DEB_W'(1);
            end
          end else begin
            stateNext = IDLE;
          end
        end
        HELD: begin
          if (!frameHit) begin
            if (DEB_FRAMES <= 1) begin
              stateNext = IDLE;
            end else begin
              debCntNext = DEB_W'(1);
              stateNext  = REL_DEB;
            end
          end
        end
        REL_DEB: begin
          if (!frameHit) begin
            if (32'(debCnt) + 32'd1 >= DEB_FRAMES) stateNext = IDLE;
            else debCntNext = debCnt + DEB_W'(1);
          end else begin
            stateNext = HELD;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // KEYDATA/STATUS registers; a latch beats a coinciding KEYDATA read, which then does not count as overrun.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      keyCode <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (latch) begin
        keyCode <= frameCode;
        valid   <= 1'b1;
      end else if (rdKey) begin
        valid <= 1'b0;
      end
      if (latch && valid && !rdKey) overrun <= 1'b1;
      else if (clrOvr) overrun <= 1'b0;
    end
  end

  // Combinational read mux, forced to zero while reset is asserted.
  always_comb begin
    statusWord                     = '0;
    statusWord[STATUS_VALID_BIT]   = valid;
    statusWord[STATUS_OVERRUN_BIT] = overrun;
    dR = '0;
    if (clrn) begin
      if (rdKey) dR = {12'b0, keyCode};
      else if (rdStat) dR = statusWord;
    end
  end

endmodule

// File: tb/tb_keypad_port.sv
// Self-checking bench for keypad_port with a frame-level reference model.
module tb_keypad_port;

  localparam int unsigned SD  = 4;
  localparam int unsigned DF  = 2;
  localparam int          DFI = 2;
  localparam int          FRAME = 4 * SD;
  localparam logic [31:0] BA = 32'hFFFFFC10;
  localparam logic [31:0] KA = BA;
  localparam logic [31:0] SA = BA + 32'd2;
  localparam int OP_NONE = 0, OP_RDKEY = 1, OP_WRSTAT = 2, OP_WRKEY = 3, OP_RDBAD = 4;

  logic        clk, clrn, isR;
  logic [3:0]  isW;
  logic [31:0] addr;
  logic [15:0] dW, dR;
  logic [3:0]  row, col;
  logic [15:0] keysDown;

  int checks = 0;
  int errors = 0;

  // reference model
  int          mPhase, mCand, mRun;
  logic [3:0]  mCode;
  logic        mValid, mOvr;
  logic        pendLatch;
  logic [3:0]  pendCode;
  logic [15:0] lastStatus, lastRead;
  logic [15:0] curKeys;

  keypad_port #(.SCAN_DIV(SD), .DEB_FRAMES(DF), .BASE_ADDR(BA)) dut (
    .clk  (clk),
    .clrn (clrn),
    .isR  (isR),
    .isW  (isW),
    .addr (addr),
    .dW   (dW),
    .dR   (dR),
    .row  (row),
    .col  (col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad matrix: a row reads low when a pressed key sits in a driven-low column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col[c] == 1'b0 && keysDown[r*4+c]) row[r] = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic int frameResult(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) return r*4+c;
    return -1;
  endfunction

  // debounce rules at frame granularity: 0 released, 1 confirming press, 2 down, 3 confirming release
  task automatic modelFrame(input int res);
    pendLatch = 1'b0;
    case (mPhase)
      0: if (res >= 0) begin
           mCand = res; mRun = 1;
           if (mRun >= DFI) begin pendLatch = 1'b1; pendCode = 4'(res); mPhase = 2; end
           else mPhase = 1;
         end
      1: if (res == mCand) begin
           mRun++;
           if (mRun >= DFI) begin pendLatch = 1'b1; pendCode = 4'(res); mPhase = 2; end
         end else mPhase = 0;
      2: if (res < 0) begin mRun = 1; mPhase = (DFI <= 1) ? 0 : 3; end
      default: if (res < 0) begin mRun++; if (mRun >= DFI) mPhase = 0; end
               else mPhase = 2;
    endcase
  endtask

  task automatic modelReset();
    mPhase = 0; mCand = 0; mRun = 0;
    mCode = '0; mValid = 1'b0; mOvr = 1'b0;
    pendLatch = 1'b0; pendCode = '0;
  endtask

  // one scan frame, starting just after the edge that opens column 0
  task automatic frame(input logic [15:0] keys, input int op = OP_NONE,
                       input logic [15:0] wdata = '0, input logic [3:0] be = 4'hF,
                       input logic [31:0] badAddr = 32'h0);
    logic rdFlag, wrClr;
    rdFlag = 1'b0; wrClr = 1'b0;
    keysDown = keys;
    case (op)
      OP_RDKEY: begin
        isR = 1'b1; addr = KA; #1;
        lastRead = dR;
        chk("keydata read", dR, {12'b0, mCode});
        rdFlag = 1'b1;
      end
      OP_WRSTAT: begin isW = be; addr = SA; dW = wdata; wrClr = wdata[1]; end
      OP_WRKEY:  begin isW = be; addr = KA; dW = wdata; end
      OP_RDBAD: begin
        isR = 1'b1; addr = badAddr; #1;
        chk("unmapped read", dR, 16'h0000);
      end
      default: ;
    endcase
    @(posedge clk);
    isR = 1'b0; isW = '0; addr = '0; dW = '0;
    if (pendLatch && mValid && !rdFlag) mOvr = 1'b1;
    else if (wrClr) mOvr = 1'b0;
    if (pendLatch) begin mCode = pendCode; mValid = 1'b1; end
    else if (rdFlag) mValid = 1'b0;
    #1;
    isR = 1'b1; addr = SA; #1;
    lastStatus = dR;
    chk("status read", dR, {14'b0, mOvr, mValid});
    chk("col in column 0", {12'b0, col}, 16'h000E);
    isR = 1'b0; addr = '0;
    repeat (FRAME - 1) @(posedge clk);
    modelFrame(frameResult(keys));
  endtask

  task automatic doReset();
    @(negedge clk);
    clrn = 1'b0; keysDown = '0;
    #1;
    isR = 1'b1; addr = SA; #1;
    chk("reset status", dR, 16'h0000);
    addr = KA; #1;
    chk("reset keydata", dR, 16'h0000);
    isR = 1'b0; addr = '0;
    chk("reset col", {12'b0, col}, 16'h000E);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    modelReset();
  endtask

  initial begin
    clrn = 1'b0; isR = 1'b0; isW = '0; addr = '0; dW = '0; keysDown = '0;
    lastStatus = '0; lastRead = '0; curKeys = '0;
    modelReset();
    doReset();
    frame(16'h0000, OP_RDKEY);

    // key 6 held for 5 frames
    frame(16'h0040); frame(16'h0040); frame(16'h0040);
    chk("key6 valid by frame 3", lastStatus, 16'h0001);
    frame(16'h0040); frame(16'h0040);
    frame(16'h0000, OP_RDKEY);
    chk("key6 keydata", lastRead, 16'h0006);
    frame(16'h0000); frame(16'h0000);

    // bounce on key 9
    frame(16'h0200); frame(16'h0000); frame(16'h0200); frame(16'h0200);
    chk("key9 no early latch", lastStatus, 16'h0000);
    frame(16'h0000);
    chk("key9 latched", lastStatus, 16'h0001);
    frame(16'h0000, OP_RDKEY);
    chk("key9 keydata", lastRead, 16'h0009);
    frame(16'h0000);

    // key 3 then key 5 unread -> overrun
    repeat (3) frame(16'h0008);
    repeat (3) frame(16'h0000);
    repeat (3) frame(16'h0020);
    repeat (3) frame(16'h0000);
    chk("overrun status", lastStatus, 16'h0003);
    frame(16'h0000, OP_WRSTAT, 16'h0002, 4'hF);
    chk("overrun cleared", lastStatus, 16'h0001);
    frame(16'h0000, OP_RDKEY);
    chk("key5 keydata", lastRead, 16'h0005);

    // read coinciding with latch of key 7 while key 2 pending
    repeat (3) frame(16'h0004);
    repeat (3) frame(16'h0000);
    frame(16'h0080); frame(16'h0080);
    frame(16'h0080, OP_RDKEY);
    chk("coincident read old code", lastRead, 16'h0002);
    chk("coincident status", lastStatus, 16'h0001);
    frame(16'h0000); frame(16'h0000);
    frame(16'h0000, OP_RDKEY);
    chk("key7 keydata", lastRead, 16'h0007);

    // keys 0 and 4 together
    repeat (3) frame(16'h0011);
    frame(16'h0000, OP_RDKEY);
    chk("same-column priority", lastRead, 16'h0000);
    frame(16'h0000); frame(16'h0000);

    // reset during press debounce with a key pending
    frame(16'h0800); frame(16'h0800);
    frame(16'h0000); frame(16'h0000);
    frame(16'h2000);
    keysDown = 16'h2000;
    repeat (5) @(posedge clk);
    doReset();
    repeat (3) frame(16'h0000);
    chk("no latch after reset", lastStatus, 16'h0000);
    frame(16'h0000, OP_RDKEY);

    // randomized frames
    curKeys = 16'h0100;
    for (int i = 0; i < 60; i++) begin
      int kSel, oSel, k1, k2, aSel;
      logic [15:0] keys;
      logic [31:0] bad;
      kSel = int'($urandom_range(0, 9));
      k1 = int'($urandom_range(0, 15));
      k2 = int'($urandom_range(0, 15));
      if (kSel < 3) keys = '0;
      else if (kSel < 7) keys = curKeys;
      else if (kSel < 9) begin curKeys = 16'(1) << k1; keys = curKeys; end
      else begin curKeys = (16'(1) << k1) | (16'(1) << k2); keys = curKeys; end
      aSel = int'($urandom_range(0, 4));
      case (aSel)
        0: bad = KA + 32'd1;
        1: bad = SA + 32'd1;
        2: bad = KA ^ 32'h8000_0000;
        3: bad = KA - 32'd2;
        default: begin bad = $urandom; if (bad == KA || bad == SA) bad = bad ^ 32'h1; end
      endcase
      oSel = int'($urandom_range(0, 9));
      case (oSel)
        6: frame(keys, OP_RDKEY);
        7: frame(keys, OP_WRSTAT, 16'($urandom), 4'($urandom_range(1, 15)));
        8: frame(keys, OP_WRKEY, 16'($urandom), 4'($urandom_range(1, 15)));
        9: frame(keys, OP_RDBAD, '0, 4'hF, bad);
        default: frame(keys);
      endcase
    end
    frame(16'h0000); frame(16'h0000, OP_RDKEY);
    frame(16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
